ext_bus_seq: RTL and testbench
==============================

# ext_bus_seq

External memory bus sequencer for the DMG core, directly downstream of the bottom datapath. It captures the 16-bit address that the IncDec stage drives on `A` and the write data from the internal `DL` bus. It then runs a four-state (T1–T4) read or write cycle on the external pins, with wait-state extension and a timeout. Read data is returned in a held latch that the core gates onto `DL`.

## Interface
Parameters:
- `WAIT_MAX`, default 15: maximum number of extra T3 cycles before forced completion. Legal range 1–255.

Ports:
- `CLK`  in  1  single core clock; one state per rising edge.
- `RES_n`  in  1  asynchronous active-low reset.
- `A`  in  16  address from the bottom IncDec output.
- `DL_wr`  in  8  write data taken from the internal `DL` bus.
- `RD_REQ`  in  1  read request; level, sampled in IDLE/T4.
- `WR_REQ`  in  1  write request; level, sampled in IDLE/T4.
- `Maybe1`  in  1  bus disable; blocks the start of new cycles.
- `WAIT`  in  1  external wait; active high.
- `MD_in`  in  8  external data pins, input side.
- `MA`  out  16  external address pins.
- `MD_out`  out  8  external data pins, output side.
- `MD_oe`  out  1  data pin output enable.
- `RD_n`  out  1  read strobe; active low.
- `WR_n`  out  1  write strobe; active low.
- `INT_SEL`  out  1  high-page (FFxx) internal access in progress.
- `DL_rd`  out  8  latched read data for `DL`.
- `BUSY`  out  1  a cycle is in T1–T4.
- `DONE`  out  1  one-clock pulse in T4.
- `TIMEOUT`  out  1  one-clock pulse in T4 of a timed-out cycle.

## Operation
States: IDLE, T1, T2, T3, T4. Transitions are evaluated on each `CLK` rising edge.

Start of a cycle:
- In IDLE or T4, with `Maybe1`=0 and `RD_REQ` or `WR_REQ` high: next state is T1.
- Otherwise IDLE or T4 goes to IDLE.
- If both requests are high, read wins and the write is dropped. The requester must re-assert the write.

Captured at entry to T1:
- `A` into an internal address register.
- `DL_wr` into `MD_out`; writes only.
- The direction bit.
- `int` = (`A[15:8]` == 8'hFF).

Per-state behaviour, external cycle (`int`=0):
- T1: `MA` takes the captured address.
  - Write: `MD_oe`=1.
  - Strobes stay high.
- T2: the selected strobe (`RD_n` or `WR_n`) goes low.
- T3: strobe held low. A wait counter, cleared at T1, controls exit:
  - `WAIT`=1 and count < `WAIT_MAX`: stay in T3 and increment the count.
  - `WAIT`=0: go to T4. On a read, `DL_rd` takes `MD_in` on this edge.
  - count == `WAIT_MAX` with `WAIT` still 1: go to T4 and assert `TIMEOUT` there. On a read, `DL_rd` takes 8'hFF.
- T4: strobes high and `DONE`=1. `MD_oe` falls at the end of T4.

Internal cycle (`int`=1):
- `MA` holds its previous value.
- No strobes; `MD_oe`=0.
- `INT_SEL`=1 in T2 and T3.
- `WAIT` is ignored, so T3 lasts exactly one cycle.
- `DL_rd` is unchanged; the internal target drives `DL`.
- `DONE` pulses in T4 as usual.

Other rules:
- `BUSY` = state ∈ {T1, T2, T3, T4}.
- `Maybe1` going high mid-cycle does not abort. The cycle completes, and only the next start is blocked.
- `A` and `DL_wr` may change after T1; they are not re-sampled until the next T1.

## Timing
- Minimum cycle: 4 clocks, T1→T4. Each wait cycle adds 1 clock.
- Back-to-back: a request seen in T4 gives T1 on the next edge, with no IDLE gap.
- `DL_rd` is valid from T4 until the next read capture.
- Write data on `MD_out` is stable from T1 through T4.

Reset (`RES_n`=0, immediate and asynchronous):
- state IDLE.
- `MA`=16'h0000.
- `RD_n`=1, `WR_n`=1.
- `MD_oe`=0, `MD_out`=8'h00.
- `DL_rd`=8'hFF.
- `INT_SEL`=0, `BUSY`=0, `DONE`=0, `TIMEOUT`=0.
- Wait count = 0.

Reset mid-cycle: strobes and `MD_oe` release in the same instant, and no `DONE` is produced. After `RES_n` rises, the first start can occur on the next edge.

All outputs are registered and glitch-free.

## Test plan
1. Read with no wait: `A`=16'hC123, `RD_REQ` pulse, `MD_in`=8'h5A.
   - `MA`=C123 from T1.
   - `RD_n` low in T2–T3.
   - `DL_rd`=5A and `DONE` in clock 4 after T1 entry.
2. Write with 3 wait cycles: `A`=16'h8000, `DL_wr`=8'h3C, `WAIT` high for 3 clocks.
   - `MD_oe`=1 and `MD_out`=3C in T1–T4.
   - `WR_n` low for 5 clocks.
   - `DONE` at clock 7.
   - `TIMEOUT`=0.
3. Timeout: `WAIT_MAX`=15, `WAIT` stuck high, read.
   - T3 lasts 16 clocks.
   - `TIMEOUT` and `DONE` assert together.
   - `DL_rd`=FF.
4. High page and back-to-back: read 16'hFF44, then 16'h0100 requested during T4.
   - First cycle: `INT_SEL` high, no strobes, `MA` unchanged.
   - Second cycle: T1 follows T4 immediately.
5. Arbitration and disable:
   - `RD_REQ` and `WR_REQ` together: a read only is performed.
   - `Maybe1`=1 in IDLE with a request: stays IDLE, `BUSY`=0.
   - `Maybe1` raised in T2: the cycle completes and `DONE` is seen.
6. Reset mid-write: `RES_n` low in T3.
   - `WR_n`=1 and `MD_oe`=0 immediately.
   - All outputs at their reset values.
   - No `DONE`.

Source files
------------

// File: rtl/ext_bus_seq.sv
// External memory bus sequencer: runs T1-T4 read/write cycles on the external pins, with
// wait-state extension, a timeout, and internal (FFxx) cycles that never touch the pins.
module ext_bus_seq #(
  parameter int unsigned WAIT_MAX = 15
) (
  input  logic        CLK,
  input  logic        RES_n,
  input  logic [15:0] A,
  input  logic [7:0]  DL_wr,
  input  logic        RD_REQ,
  input  logic        WR_REQ,
  input  logic        Maybe1,
  input  logic        WAIT,
  input  logic [7:0]  MD_in,
  output logic [15:0] MA,
  output logic [7:0]  MD_out,
  output logic        MD_oe,
  output logic        RD_n,
  output logic        WR_n,
  output logic        INT_SEL,
  output logic [7:0]  DL_rd,
  output logic        BUSY,
  output logic        DONE,
  output logic        TIMEOUT
);

  localparam logic [7:0] WaitMax = 8'(WAIT_MAX);

  typedef enum logic [2:0] {StIdle, StT1, StT2, StT3, StT4} state_e;

  state_e     state_q;
  logic [7:0] wait_cnt_q;
  logic       is_wr_q;
  logic       int_q;

  logic start;
  logic start_wr;
  logic start_int;

  // Read wins when both requests are high; the dropped write must be re-requested.
  always_comb begin
    start     = !Maybe1 && (RD_REQ || WR_REQ);
    start_wr  = WR_REQ && !RD_REQ;
    start_int = (A[15:8] == 8'hFF);
  end

  always_ff @(posedge CLK or negedge RES_n) begin
    if (!RES_n) begin
      state_q    <= StIdle;
      wait_cnt_q <= 8'd0;
      is_wr_q    <= 1'b0;
      int_q      <= 1'b0;
      MA         <= 16'h0000;
      MD_out     <= 8'h00;
      MD_oe      <= 1'b0;
      RD_n       <= 1'b1;
      WR_n       <= 1'b1;
      INT_SEL    <= 1'b0;
      DL_rd      <= 8'hFF;
      BUSY       <= 1'b0;
      DONE       <= 1'b0;
      TIMEOUT    <= 1'b0;
    end else begin
      DONE    <= 1'b0;
      TIMEOUT <= 1'b0;
      unique case (state_q)
        StIdle, StT4: begin
          if (start) begin
            state_q    <= StT1;
            BUSY       <= 1'b1;
            wait_cnt_q <= 8'd0;
            is_wr_q    <= start_wr;
            int_q      <= start_int;
            MD_oe      <= start_wr && !start_int;
            if (!start_int) MA <= A;
            if (start_wr) MD_out <= DL_wr;
          end else begin
            state_q <= StIdle;
            BUSY    <= 1'b0;
            MD_oe   <= 1'b0;
          end
        end
        StT1: begin
          state_q <= StT2;
          INT_SEL <= int_q;
          if (!int_q) begin
            RD_n <= is_wr_q;
            WR_n <= !is_wr_q;
          end
        end
        StT2: begin
          state_q <= StT3;
        end
        StT3: begin
          if (!int_q && WAIT && (wait_cnt_q != WaitMax)) begin
            wait_cnt_q <= wait_cnt_q + 8'd1;
          end else begin
            state_q <= StT4;
            RD_n    <= 1'b1;
            WR_n    <= 1'b1;
            INT_SEL <= 1'b0;
            DONE    <= 1'b1;
            // Internal cycles ignore WAIT and leave DL_rd to the internal target.
            if (!int_q) begin
              TIMEOUT <= WAIT;
              if (!is_wr_q) DL_rd <= WAIT ? 8'hFF : MD_in;
            end
          end
        end
        default: begin
          state_q <= StIdle;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_ext_bus_seq.sv
// Self-checking bench for ext_bus_seq: per-scenario tasks plus a DONE-driven scoreboard
// that compares returned read data and timeout flags in completion order.
module tb_ext_bus_seq;

  logic        CLK = 1'b0;
  logic        RES_n;
  logic [15:0] A;
  logic [7:0]  DL_wr;
  logic        RD_REQ, WR_REQ, Maybe1, WAIT;
  logic [7:0]  MD_in;
  logic [15:0] MA;
  logic [7:0]  MD_out;
  logic        MD_oe, RD_n, WR_n, INT_SEL;
  logic [7:0]  DL_rd;
  logic        BUSY, DONE, TIMEOUT;

  int errors = 0;
  int checks = 0;

  typedef struct {
    logic [7:0] dl;
    logic       to;
  } exp_t;

  exp_t       sb_q[$];
  logic [7:0] model_dl;

  ext_bus_seq #(.WAIT_MAX(15)) dut (
    .CLK(CLK), .RES_n(RES_n), .A(A), .DL_wr(DL_wr), .RD_REQ(RD_REQ), .WR_REQ(WR_REQ),
    .Maybe1(Maybe1), .WAIT(WAIT), .MD_in(MD_in), .MA(MA), .MD_out(MD_out), .MD_oe(MD_oe),
    .RD_n(RD_n), .WR_n(WR_n), .INT_SEL(INT_SEL), .DL_rd(DL_rd), .BUSY(BUSY), .DONE(DONE),
    .TIMEOUT(TIMEOUT)
  );

  always #5 CLK = ~CLK;

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  // Scoreboard: every DONE retires the oldest expected completion.
  always @(negedge CLK) begin
    if (RES_n === 1'b1 && DONE === 1'b1) begin
      checks++;
      if (sb_q.size() == 0) begin
        errors++;
        $display("FAIL sb_unexpected_done: DONE with empty scoreboard, DL_rd=%h", DL_rd);
      end else begin
        exp_t e;
        e = sb_q.pop_front();
        if (DL_rd !== e.dl || TIMEOUT !== e.to) begin
          errors++;
          $display("FAIL sb_completion: DL_rd=%h TIMEOUT=%b, want DL_rd=%h TIMEOUT=%b",
                   DL_rd, TIMEOUT, e.dl, e.to);
        end
      end
    end
  end

  task automatic test_reset();
    RES_n = 1'b0; A = 16'h0; DL_wr = 8'h0; RD_REQ = 1'b0; WR_REQ = 1'b0;
    Maybe1 = 1'b0; WAIT = 1'b0; MD_in = 8'h0; model_dl = 8'hFF;
    repeat (3) tick();
    checks++;
    if (MA !== 16'h0000 || MD_out !== 8'h00 || MD_oe !== 1'b0 || RD_n !== 1'b1 ||
        WR_n !== 1'b1 || DL_rd !== 8'hFF) begin
      errors++;
      $display("FAIL reset_pins: MA=%h MD_out=%h MD_oe=%b RD_n=%b WR_n=%b DL_rd=%h, want 0000 00 0 1 1 FF",
               MA, MD_out, MD_oe, RD_n, WR_n, DL_rd);
    end
    checks++;
    if (INT_SEL !== 1'b0 || BUSY !== 1'b0 || DONE !== 1'b0 || TIMEOUT !== 1'b0) begin
      errors++;
      $display("FAIL reset_flags: INT_SEL=%b BUSY=%b DONE=%b TIMEOUT=%b, want 0 0 0 0",
               INT_SEL, BUSY, DONE, TIMEOUT);
    end
    RES_n = 1'b1;
    tick();
  endtask

  task automatic test_read_no_wait();
    int   done_clk = 0;
    int   rd_low = 0;
    logic ma_ok = 1'b1;
    A = 16'hC123; MD_in = 8'h5A; RD_REQ = 1'b1;
    model_dl = 8'h5A;
    sb_q.push_back('{dl: 8'h5A, to: 1'b0});
    tick();
    RD_REQ = 1'b0; A = 16'h0000;
    checks++;
    if (MA !== 16'hC123 || RD_n !== 1'b1 || BUSY !== 1'b1) begin
      errors++;
      $display("FAIL rd_t1: MA=%h RD_n=%b BUSY=%b, want C123 1 1", MA, RD_n, BUSY);
    end
    for (int c = 2; c <= 12 && done_clk == 0; c++) begin
      tick();
      if (RD_n === 1'b0) rd_low++;
      if (MA !== 16'hC123) ma_ok = 1'b0;
      if (DONE === 1'b1) done_clk = c;
    end
    checks++;
    if (done_clk != 4) begin
      errors++;
      $display("FAIL rd_done_clock: got %0d, want 4", done_clk);
    end
    checks++;
    if (rd_low != 2 || !ma_ok) begin
      errors++;
      $display("FAIL rd_strobe: RD_n low %0d clocks ma_ok=%b, want 2 1", rd_low, ma_ok);
    end
    tick();
    checks++;
    if (BUSY !== 1'b0) begin
      errors++;
      $display("FAIL rd_idle: BUSY=%b, want 0", BUSY);
    end
  endtask

  task automatic test_write_wait();
    int   done_clk = 0;
    int   wr_low = 0;
    logic md_ok = 1'b1;
    A = 16'h8000; DL_wr = 8'h3C; WR_REQ = 1'b1; WAIT = 1'b1;
    sb_q.push_back('{dl: model_dl, to: 1'b0});
    tick();
    WR_REQ = 1'b0; A = 16'h1111; DL_wr = 8'h00;
    if (MD_oe !== 1'b1 || MD_out !== 8'h3C) md_ok = 1'b0;
    for (int c = 2; c <= 20 && done_clk == 0; c++) begin
      tick();
      if (c == 6) WAIT = 1'b0;
      if (WR_n === 1'b0) wr_low++;
      if (MD_oe !== 1'b1 || MD_out !== 8'h3C || RD_n !== 1'b1) md_ok = 1'b0;
      if (DONE === 1'b1) begin
        done_clk = c;
        checks++;
        if (TIMEOUT !== 1'b0) begin
          errors++;
          $display("FAIL wr_timeout: TIMEOUT=%b, want 0", TIMEOUT);
        end
      end
    end
    WAIT = 1'b0;
    checks++;
    if (done_clk != 7) begin
      errors++;
      $display("FAIL wr_done_clock: got %0d, want 7", done_clk);
    end
    checks++;
    if (wr_low != 5) begin
      errors++;
      $display("FAIL wr_strobe_len: WR_n low %0d clocks, want 5", wr_low);
    end
    checks++;
    if (!md_ok) begin
      errors++;
      $display("FAIL wr_data_hold: MD_oe/MD_out not held, last MD_oe=%b MD_out=%h want 1 3C",
               MD_oe, MD_out);
    end
    tick();
    checks++;
    if (MD_oe !== 1'b0 || BUSY !== 1'b0) begin
      errors++;
      $display("FAIL wr_release: MD_oe=%b BUSY=%b, want 0 0", MD_oe, BUSY);
    end
  endtask

  task automatic test_timeout();
    int done_clk = 0;
    int rd_low = 0;
    A = 16'h1234; MD_in = 8'h77; RD_REQ = 1'b1; WAIT = 1'b1;
    model_dl = 8'hFF;
    sb_q.push_back('{dl: 8'hFF, to: 1'b1});
    tick();
    RD_REQ = 1'b0;
    for (int c = 2; c <= 40 && done_clk == 0; c++) begin
      tick();
      if (RD_n === 1'b0) rd_low++;
      if (DONE === 1'b1) begin
        done_clk = c;
        checks++;
        if (TIMEOUT !== 1'b1 || DL_rd !== 8'hFF) begin
          errors++;
          $display("FAIL to_flags: TIMEOUT=%b DL_rd=%h, want 1 FF", TIMEOUT, DL_rd);
        end
      end
    end
    WAIT = 1'b0;
    checks++;
    if (done_clk != 19 || rd_low != 17) begin
      errors++;
      $display("FAIL to_length: done clock %0d RD_n low %0d, want 19 17", done_clk, rd_low);
    end
    tick();
  endtask

  task automatic test_back_to_back();
    int   done_clk = 0;
    int   done2 = 0;
    int   int_cnt = 0;
    logic quiet = 1'b1;
    A = 16'hFF44; MD_in = 8'hAA; RD_REQ = 1'b1; WAIT = 1'b1;
    sb_q.push_back('{dl: model_dl, to: 1'b0});
    tick();
    RD_REQ = 1'b0;
    for (int c = 1; c <= 12 && done_clk == 0; c++) begin
      if (c > 1) tick();
      if (INT_SEL === 1'b1) int_cnt++;
      if (RD_n !== 1'b1 || WR_n !== 1'b1 || MD_oe !== 1'b0 || MA !== 16'h1234) quiet = 1'b0;
      if (DONE === 1'b1) begin
        done_clk = c;
        A = 16'h0100; MD_in = 8'hC3; RD_REQ = 1'b1; WAIT = 1'b0;
        model_dl = 8'hC3;
        sb_q.push_back('{dl: 8'hC3, to: 1'b0});
      end
    end
    checks++;
    if (done_clk != 4 || int_cnt != 2) begin
      errors++;
      $display("FAIL hp_cycle: done clock %0d INT_SEL clocks %0d, want 4 2", done_clk, int_cnt);
    end
    checks++;
    if (!quiet) begin
      errors++;
      $display("FAIL hp_quiet: pins active, MA=%h RD_n=%b MD_oe=%b, want 1234 1 0",
               MA, RD_n, MD_oe);
    end
    tick();
    RD_REQ = 1'b0;
    checks++;
    if (BUSY !== 1'b1 || DONE !== 1'b0 || MA !== 16'h0100) begin
      errors++;
      $display("FAIL b2b_t1: BUSY=%b DONE=%b MA=%h, want 1 0 0100", BUSY, DONE, MA);
    end
    for (int c = 2; c <= 12 && done2 == 0; c++) begin
      tick();
      if (DONE === 1'b1) done2 = c;
    end
    checks++;
    if (done2 != 4) begin
      errors++;
      $display("FAIL b2b_done_clock: got %0d, want 4", done2);
    end
    tick();
  endtask

  task automatic test_arbitration_disable();
    int   done_clk = 0;
    int   rd_low = 0;
    logic wr_seen = 1'b0;
    logic busy_seen = 1'b0;
    A = 16'h2000; DL_wr = 8'h99; MD_in = 8'h12; RD_REQ = 1'b1; WR_REQ = 1'b1;
    model_dl = 8'h12;
    sb_q.push_back('{dl: 8'h12, to: 1'b0});
    tick();
    RD_REQ = 1'b0; WR_REQ = 1'b0;
    checks++;
    if (MD_oe !== 1'b0 || MD_out !== 8'h3C) begin
      errors++;
      $display("FAIL arb_no_write: MD_oe=%b MD_out=%h, want 0 3C", MD_oe, MD_out);
    end
    for (int c = 2; c <= 12 && done_clk == 0; c++) begin
      tick();
      if (WR_n === 1'b0) wr_seen = 1'b1;
      if (RD_n === 1'b0) rd_low++;
      if (DONE === 1'b1) done_clk = c;
    end
    checks++;
    if (wr_seen || rd_low != 2 || done_clk != 4) begin
      errors++;
      $display("FAIL arb_read_only: WR_n low=%b RD_n low %0d done %0d, want 0 2 4",
               wr_seen, rd_low, done_clk);
    end
    tick();
    Maybe1 = 1'b1; RD_REQ = 1'b1; A = 16'h3000; MD_in = 8'h34;
    for (int c = 0; c < 3; c++) begin
      tick();
      if (BUSY !== 1'b0) busy_seen = 1'b1;
    end
    checks++;
    if (busy_seen) begin
      errors++;
      $display("FAIL dis_blocked: BUSY seen high=%b, want 0", busy_seen);
    end
    Maybe1 = 1'b0;
    model_dl = 8'h34;
    sb_q.push_back('{dl: 8'h34, to: 1'b0});
    tick();
    RD_REQ = 1'b0;
    tick();
    Maybe1 = 1'b1;
    done_clk = 0;
    for (int c = 3; c <= 12 && done_clk == 0; c++) begin
      tick();
      if (DONE === 1'b1) done_clk = c;
    end
    checks++;
    if (done_clk != 4) begin
      errors++;
      $display("FAIL dis_midcycle: done clock %0d, want 4", done_clk);
    end
    tick();
    Maybe1 = 1'b0;
  endtask

  task automatic test_reset_mid_write();
    logic done_seen = 1'b0;
    A = 16'h4000; DL_wr = 8'hE7; WR_REQ = 1'b1; WAIT = 1'b1;
    tick();
    WR_REQ = 1'b0;
    tick();
    tick();
    checks++;
    if (WR_n !== 1'b0 || MD_oe !== 1'b1) begin
      errors++;
      $display("FAIL rst_pre: WR_n=%b MD_oe=%b, want 0 1", WR_n, MD_oe);
    end
    #2 RES_n = 1'b0;
    #1;
    checks++;
    if (WR_n !== 1'b1 || MD_oe !== 1'b0 || RD_n !== 1'b1 || MA !== 16'h0000 ||
        MD_out !== 8'h00 || DL_rd !== 8'hFF) begin
      errors++;
      $display("FAIL rst_async_pins: WR_n=%b MD_oe=%b RD_n=%b MA=%h MD_out=%h DL_rd=%h, want 1 0 1 0000 00 FF",
               WR_n, MD_oe, RD_n, MA, MD_out, DL_rd);
    end
    checks++;
    if (BUSY !== 1'b0 || DONE !== 1'b0 || INT_SEL !== 1'b0 || TIMEOUT !== 1'b0) begin
      errors++;
      $display("FAIL rst_async_flags: BUSY=%b DONE=%b INT_SEL=%b TIMEOUT=%b, want 0 0 0 0",
               BUSY, DONE, INT_SEL, TIMEOUT);
    end
    WAIT = 1'b0;
    for (int c = 0; c < 2; c++) begin
      tick();
      if (DONE !== 1'b0) done_seen = 1'b1;
    end
    model_dl = 8'h66;
    A = 16'h5555; MD_in = 8'h66; RD_REQ = 1'b1;
    RES_n = 1'b1;
    tick();
    RD_REQ = 1'b0;
    if (DONE !== 1'b0) done_seen = 1'b1;
    checks++;
    if (done_seen || BUSY !== 1'b1 || MA !== 16'h5555) begin
      errors++;
      $display("FAIL rst_restart: done_seen=%b BUSY=%b MA=%h, want 0 1 5555",
               done_seen, BUSY, MA);
    end
    sb_q.push_back('{dl: 8'h66, to: 1'b0});
    repeat (4) tick();
  endtask

  initial begin
    test_reset();
    test_read_no_wait();
    test_write_wait();
    test_timeout();
    test_back_to_back();
    test_arbitration_disable();
    test_reset_mid_write();
    tick();
    checks++;
    if (sb_q.size() != 0) begin
      errors++;
      $display("FAIL sb_drained: %0d completions outstanding, want 0", sb_q.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
